// File: rtl/codegen_pkg.sv
// Shared types and defaults for the code-generator round-robin scheduler.
package codegen_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int LEN_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single requester would still need a 1-bit ID field.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/codegen_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ.
module rr_arbiter
  import codegen_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] winner_oh_o,
  output logic [ID_W-1:0]  winner_idx_o,
  output logic             any_req_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner_oh_o  = '0;
    winner_idx_o = '0;
    any_req_o    = |req_i;
    found        = 1'b0;
    idx          = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        found            = 1'b1;
        winner_oh_o[idx] = 1'b1;
        winner_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/codegen_arb.sv
// Round-robin scheduler sharing one code generator among N_REQ requesters;
// drives the generator start for exactly burst_len cycles per grant.
module codegen_arb
  import codegen_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] burst_len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   cg_start,
  input  logic [DATA_W-1:0]      cg_data,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic [ID_W-1:0]        out_id,
  output logic [N_REQ-1:0]       done,
  output logic [1:0]             dbg_state
);

  // Handshake: req is a level held until the matching done pulse; gnt is high
  // from the cycle after arbitration through the DONE cycle, out_valid marks
  // each code, done is a one-cycle pulse and no ready/backpressure exists.

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic [N_REQ-1:0]  win_oh;
  logic [ID_W-1:0]   win_idx;
  logic              any_req;
  logic [LEN_W-1:0]  win_len;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .winner_oh_o  (win_oh),
    .winner_idx_o (win_idx),
    .any_req_o    (any_req)
  );

  assign win_len = burst_len[win_idx*LEN_W +: LEN_W];

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d    = win_idx;
          cnt_d   = win_len;
          gnt_d   = win_oh;
          state_d = (win_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // The finished requester drops to lowest priority next round.
        ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  // All outputs decode from registers, so an asynchronous reset clears them at once.
  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign cg_start  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN);
  assign out_data  = (state_q == ST_RUN) ? cg_data : '0;
  assign out_id    = (state_q != ST_IDLE) ? id_q : '0;
  assign done      = (state_q == ST_DONE) ? gnt_q : '0;
  assign dbg_state = state_q;

endmodule

// File: doc/codegen_arb.md
Name: codegen_arb

Overview:
- Round-robin scheduler that shares the team's single 8-bit code generator counter among N requesters.
- Each requester asks for a burst of consecutive codes. The arbiter grants one requester at a time and drives the generator's start enable for exactly that many cycles.
- It steers the generator's data back to the granted requester, tagged with a requester ID and valid.
- Sits between requesting client blocks and the code generator instance; the generator's reset is the same rst_l.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of each burst-length field.
- DATA_W, 8, code width; must match the generator data width.
- ID_W, $clog2(N_REQ), width of the requester ID.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset.
- req  in  N_REQ  per-requester burst request, level; held until the matching done pulse.
- burst_len  in  N_REQ*LEN_W  requester i length in bits [i*LEN_W +: LEN_W]; sampled at grant.
- gnt  out  N_REQ  one-hot grant, high from grant through the DONE cycle.
- busy  out  1  high in any state other than IDLE.
- cg_start  out  1  to generator start; high only in RUN.
- cg_data  in  DATA_W  from generator data (current counter value).
- out_data  out  DATA_W  code to the granted requester; equals cg_data while out_valid is high, 0 otherwise.
- out_valid  out  1  high each RUN cycle, exactly len cycles per burst.
- out_id  out  ID_W  index of the granted requester; 0 when idle.
- done  out  N_REQ  one-cycle one-hot pulse at burst end.

Behaviour:
- Reset: rst_l is asynchronous, active-low; clock is clk. All outputs 0, state IDLE, round-robin pointer 0, length counter 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Pick winner = first set req bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the winner index and its burst_len.
  - Next cycle: gnt[winner]=1 and out_id=winner.
  - Go to RUN if len != 0; go to DONE if len == 0, in which case no codes are issued.
- RUN:
  - cg_start=1 and out_valid=1. out_data=cg_data; the generator increments at the edge, so the requester sees consecutive codes.
  - Counter decrements each cycle. When the counter equals 1, the next state is DONE.
  - A burst of len L therefore produces exactly L valid cycles, starting 1 cycle after grant.
- DONE:
  - done[id]=1 for one cycle; gnt stays high this cycle.
  - Pointer becomes id+1, wrapping N_REQ-1 to 0. Next state IDLE; gnt drops.
- Minimum spacing: one IDLE cycle between bursts. Back-to-back arbitration is re-evaluated in IDLE.
- req deasserted mid-burst: ignored; the burst completes and done still pulses.
- req changes on non-granted lines during a burst: no effect until the next IDLE.
- Requester still requesting after its done: eligible again, but lowest priority relative to other requesters.
- Code wrap: the generator rolls 255 to 0 naturally; the arbiter passes the value through unchanged, no special handling.
- burst_len = max (255): 255 valid cycles, with no counter overflow.
- Reset mid-burst: all outputs return to 0 immediately and asynchronously; the burst is discarded and no done pulse is issued. The generator resets to 0 on the same rst_l.

Decomposition:
- Shared package codegen_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - defaults for N_REQ, LEN_W and DATA_W;
  - the ID_W function.
- One sub-module, rr_arbiter:
  - purely combinational winner selection;
  - inputs req and pointer; outputs one-hot winner, index, and any_req.
- Pointer, FSM, length counter and output muxing remain in codegen_arb.

Test Plan:
- Single burst: reset, generator at 0; req[0]=1, len0=3 -> gnt[0] next cycle; out_valid for 3 cycles with out_data 0,1,2 and out_id 0; done[0] pulses; generator reads 3.
- Round-robin: req=4'b1111, all lengths 2, pointer 0 -> grant order 0,1,2,3,0; each burst gets 2 consecutive codes (0-1, 2-3, 4-5, 6-7, 8-9).
- Zero length: req[2]=1, len2=0 -> gnt[2] for one cycle, no out_valid, done[2] pulses, generator value unchanged.
- Wrap: generator preloaded to 254 by running earlier bursts; len=4 -> out_data 254,255,0,1.
- Reset mid-burst: len=10, assert rst_l low after 4 valid cycles -> all outputs 0 asynchronously, no done; after release, pointer 0 and the generator restarts at 0.
- Late deassert/priority: req[1] drops during its burst -> burst completes with done[1]; with req[1] and req[3] both held high, after 1's burst the grant goes to 3.
